// File: rtl/alu_arb.sv
// -----------------------------------------------------------------------------
// alu_arb -- two-requester front end for one shared combinational ALU.
//
// Operation:
//   The FSM runs IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: one valid requester is granted and accepted.
//   EXEC: the registered operands drive the ALU, and its result is captured.
//   RESP: the result is held on rsp_data until the granted requester takes it.
//   One operation completes at most every three cycles.
//
// Arbitration policy (compile-time macro ALU_ARB_FIXED_PRIO_EN):
//   undefined : round-robin. A last-grant register hands a tie to the
//               requester that was not granted last. After reset, requester 0
//               wins the first tie.
//   defined   : fixed priority. Requester 0 always wins a tie, and there is
//               no last-grant register.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   req_valid/req_ready per-requester request handshake (bit n = requester n)
//   req_op/req_a/req_b  per-requester payload; requester n at [n*W +: W]
//   rsp_valid/rsp_ready per-requester response handshake
//   rsp_data            shared result bus, valid for the requester whose
//                       rsp_valid bit is high
//   alu_op/alu_a/alu_b  registered operands to the external ALU
//   alu_result          combinational ALU result
//   busy                high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arb #(
  parameter int DW  = 32,
  parameter int OPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*OPW-1:0] req_op,
  input  logic [2*DW-1:0]  req_a,
  input  logic [2*DW-1:0]  req_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [OPW-1:0]   alu_op,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  input  logic [DW-1:0]    alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   result_q, result_d;
  logic            grant_q, grant_d;    // index of the requester in flight
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic            last_q, last_d;      // index of the most recent grant
`endif

  logic            grant_sel;           // requester that wins this cycle

  // Winner selection. This value is only used when at least one request is
  // valid, so the all-idle case does not need separate handling.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_sel = ~req_valid[0];
`else
    if (&req_valid) grant_sel = ~last_q;
    else            grant_sel = req_valid[1];
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default before the case statement. If a state
    //       left one unassigned, synthesis would infer a latch to hold it.
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    grant_d   = grant_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    req_ready = 2'b00;
    rsp_valid = 2'b00;

    unique case (state_q)
      IDLE: begin
        // Gating with rst keeps req_ready low for the whole reset window,
        // even though the state register already reads IDLE.
        if ((|req_valid) && !rst) begin
          req_ready[grant_sel] = 1'b1;
          op_d    = grant_sel ? req_op[OPW +: OPW] : req_op[0 +: OPW];
          a_d     = grant_sel ? req_a[DW +: DW]    : req_a[0 +: DW];
          b_d     = grant_sel ? req_b[DW +: DW]    : req_b[0 +: DW];
          grant_d = grant_sel;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d  = grant_sel;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        // A ready bit from the requester that was not granted is ignored.
        if (rsp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well, not only the
      //       control state. Their values drive the alu_* and rsp_data
      //       outputs directly, so those outputs read 0 during reset.
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      grant_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments. Every flop samples its value from
      //       before the edge, so the order of these lines does not matter.
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      grant_q  <= grant_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  // The ALU only ever sees the captured operands, so a requester can change
  // its inputs while an operation is in flight.
  assign alu_op   = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign rsp_data = result_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_arb -- testbench for alu_arb.
//
// Structure:
//   - The external ALU is a small function of alu_op, alu_a and alu_b.
//   - A reference model follows the transaction-level rules:
//       * the arbitration rule decides the winner;
//       * a response is due two cycles after acceptance;
//       * the response is held until it is taken.
//   - On every acceptance, the model pushes the expected result into the
//     queue of the granted requester.
//   - A monitor pops that queue whenever the DUT completes a response
//     handshake, and compares rsp_data with the popped value.
//   - Directed sequences run first, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_alu_arb;
  localparam int DW  = 32;
  localparam int OPW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*OPW-1:0] req_op;
  logic [2*DW-1:0]  req_a;
  logic [2*DW-1:0]  req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic [OPW-1:0]   alu_op;
  logic [DW-1:0]    alu_a;
  logic [DW-1:0]    alu_b;
  logic [DW-1:0]    alu_result;
  logic             busy;

  logic [OPW-1:0]   op_r [2];
  logic [DW-1:0]    a_r  [2];
  logic [DW-1:0]    b_r  [2];

  assign req_op = {op_r[1], op_r[0]};
  assign req_a  = {a_r[1],  a_r[0]};
  assign req_b  = {b_r[1],  b_r[0]};

  alu_arb #(.DW(DW), .OPW(OPW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // External ALU. Opcode 2 is add.
  function automatic logic [DW-1:0] alu_fn(input logic [OPW-1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op[2:0])
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a + b;
      3'd3:    r = a - b;
      3'd4:    r = a ^ b;
      3'd5:    r = a << b[4:0];
      3'd6:    r = a >> b[4:0];
      default: r = ~a;
    endcase
    return op[3] ? ~r : r;
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arbitration rule as a one-hot grant.
  //   Only one request valid : that requester wins.
  //   Both valid, fixed      : requester 0 wins.
  //   Both valid, round-robin: the requester that was not granted last wins.
  function automatic logic [1:0] pick(input logic [1:0] v, input bit last);
    if (v != 2'b11) return v;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 2'b01;
`else
    return last ? 2'b01 : 2'b10;
`endif
  endfunction

  // ---------------- reference model + scoreboard monitor -------------------
  int              cyc = 0;
  bit              in_flight = 1'b0;
  int              acc_cyc = 0;
  bit              m_grant = 1'b0;
  bit              m_last = 1'b1;
  logic [OPW-1:0]  m_op;
  logic [DW-1:0]   m_a, m_b;
  logic [DW-1:0]   exp_q0[$];
  logic [DW-1:0]   exp_q1[$];
  int              grant_log[$];
  bit              hold_prev = 1'b0;
  logic [DW-1:0]   data_prev;

  always @(negedge clk) begin : monitor
    logic [1:0]    exp_ready, exp_rv, hs;
    logic [DW-1:0] e;
    cyc++;
    if (rst) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_alu_op",    64'(alu_op),    64'd0);
      check("rst_alu_a",     64'(alu_a),     64'd0);
      check("rst_alu_b",     64'(alu_b),     64'd0);
      check("rst_rsp_data",  64'(rsp_data),  64'd0);
      in_flight = 1'b0;
      m_last    = 1'b1;
      hold_prev = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
      grant_log.delete();
    end else begin
      exp_ready = in_flight ? 2'b00 : pick(req_valid, m_last);
      exp_rv    = (in_flight && cyc >= acc_cyc + 2) ? (m_grant ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("busy",      64'(busy),      64'(in_flight));
      if (in_flight) begin
        check("alu_op_held", 64'(alu_op), 64'(m_op));
        check("alu_a_held",  64'(alu_a),  64'(m_a));
        check("alu_b_held",  64'(alu_b),  64'(m_b));
      end
      if (hold_prev) check("rsp_data_stable", 64'(rsp_data), 64'(data_prev));
      hs        = rsp_valid & rsp_ready;
      hold_prev = (rsp_valid != 2'b00) && (hs == 2'b00);
      data_prev = rsp_data;

      // Scoreboard: a completed DUT handshake consumes one expected result.
      if (hs[0]) begin
        if (exp_q0.size() == 0) check("rsp0_unexpected", 64'(hs[0]), 64'd0);
        else begin
          e = exp_q0.pop_front();
          check("rsp0_data", 64'(rsp_data), 64'(e));
        end
      end
      if (hs[1]) begin
        if (exp_q1.size() == 0) check("rsp1_unexpected", 64'(hs[1]), 64'd0);
        else begin
          e = exp_q1.pop_front();
          check("rsp1_data", 64'(rsp_data), 64'(e));
        end
      end

      // Advance the model.
      if (in_flight) begin
        if (exp_rv != 2'b00 && rsp_ready[m_grant]) in_flight = 1'b0;
      end else if (exp_ready != 2'b00) begin
        m_grant = exp_ready[1];
        m_last  = m_grant;
        m_op    = op_r[m_grant];
        m_a     = a_r[m_grant];
        m_b     = b_r[m_grant];
        e       = alu_fn(m_op, m_a, m_b);
        if (m_grant) exp_q1.push_back(e);
        else         exp_q0.push_back(e);
        grant_log.push_back(int'(m_grant));
        in_flight = 1'b1;
        acc_cyc   = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string name, input int n, input logic [DW-1:0] exp);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid[n]) break;
    end
    if (k == 20) check({name, "_timeout"}, 64'(rsp_valid[n]), 64'd1);
    else         check(name, 64'(rsp_data), 64'(exp));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [1:0] acc;
    int exp_order [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int n = 0; n < 2; n++) begin
      op_r[n] = '0;
      a_r[n]  = '0;
      b_r[n]  = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy",     64'(busy),     64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);

    // Tie after reset: both requesters valid, responses always accepted.
    @(posedge clk);
    #1;
    rst = 1'b0;
    op_r[0] = 4'h2; a_r[0] = 32'd10; b_r[0] = 32'd1;
    op_r[1] = 4'h3; a_r[1] = 32'd50; b_r[1] = 32'd8;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    repeat (12) @(negedge clk);
    step();
    req_valid = 2'b00;
    check("tie_count_ge4", 64'(grant_log.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size())
        check($sformatf("tie_grant%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    step();
    step();

    // Single request, add: 5 + 7 = 12 two cycles after the request cycle.
    op_r[0] = 4'h2; a_r[0] = 32'd5; b_r[0] = 32'd7;
    req_valid = 2'b01;
    @(negedge clk);
    check("t040_req_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    check("t040_exec_no_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check("t040_rsp_valid", 64'(rsp_valid), 64'h1);
    check("t040_rsp_data",  64'(rsp_data),  64'd12);
    step();

    // Operand isolation: req_a changes right after acceptance.
    op_r[0] = 4'h2; a_r[0] = 32'd5; b_r[0] = 32'd1;
    req_valid = 2'b01;
    @(negedge clk);
    check("t043_req_ready", 64'(req_ready), 64'h1);
    step();
    a_r[0] = 32'd9;
    req_valid = 2'b00;
    @(negedge clk);
    check("t043_alu_a", 64'(alu_a), 64'd5);
    @(negedge clk);
    check("t043_rsp_data", 64'(rsp_data), 64'd6);
    step();

    // Response backpressure on requester 1, with requester 0 waiting.
    rsp_ready = 2'b00;
    op_r[1] = 4'h3; a_r[1] = 32'd20; b_r[1] = 32'd8;
    req_valid = 2'b10;
    @(negedge clk);
    check("t042_req_ready", 64'(req_ready), 64'h2);
    step();
    op_r[0] = 4'h2; a_r[0] = 32'd1; b_r[0] = 32'd1;
    req_valid = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t042_hold_valid", 64'(rsp_valid), 64'h2);
      check("t042_hold_data",  64'(rsp_data),  64'd12);
      check("t042_hold_ready", 64'(req_ready), 64'd0);
    end
    step();
    rsp_ready = 2'b10;
    @(negedge clk);
    check("t042_hs_req_ready", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    check("t042_next_accept", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (3) step();

    // Reset asserted in RESP aborts the operation.
    op_r[0] = 4'h2; a_r[0] = 32'd3; b_r[0] = 32'd4;
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    @(negedge clk);
    check("t044_req_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("t044_rsp_before", 64'(rsp_valid), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("t044_rsp_drop",  64'(rsp_valid), 64'd0);
    check("t044_busy_drop", 64'(busy),      64'd0);
    step();
    step();
    rst = 1'b0;
    op_r[0] = 4'h2; a_r[0] = 32'd1; b_r[0] = 32'd1;
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("t044_first_accept", 64'(req_ready), 64'h1);
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Boundary operands: the addition wraps to zero.
    op_r[0] = 4'h2; a_r[0] = 32'hFFFF_FFFF; b_r[0] = 32'd1;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_rsp("t045_wrap", 0, 32'h0000_0000);
    repeat (2) step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      for (int n = 0; n < 2; n++) begin
        if (!req_valid[n] || acc[n]) begin
          req_valid[n] = ($urandom_range(1, 0) == 1);
          op_r[n]      = OPW'($urandom);
          a_r[n]       = ($urandom_range(7, 0) == 0) ? '1 : DW'($urandom);
          b_r[n]       = ($urandom_range(7, 0) == 0) ? DW'(1) : DW'($urandom);
        end else if ($urandom_range(7, 0) == 0) begin
          req_valid[n] = 1'b0;
        end
      end
      rsp_ready[0] = ($urandom_range(3, 0) != 0);
      rsp_ready[1] = ($urandom_range(3, 0) != 0);
    end

    // Drain the block and confirm every expected response was delivered.
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (6) step();
    @(negedge clk);
    check("drain_q0",   64'(exp_q0.size()), 64'd0);
    check("drain_q1",   64'(exp_q1.size()), 64'd0);
    check("drain_busy", 64'(busy),          64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
